// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based stall and forwarding control for the 5-stage MIPS pipeline.
// Define HAZARD_MDU_EN to include the HI/LO unit busy countdown (md_busy, MDU stall).
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       d_md_start,
    input  logic       d_md_div,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       fwd_rt_m,
    output logic       md_busy
);
    logic [4:0] r_e_rs, r_e_rt, r_e_a3, r_m_rt, r_m_a3, r_w_a3;
    logic [1:0] r_e_tnew, r_m_tnew;
    logic       w_stall_rs, w_stall_rt, w_stall_md;

    // A nearer producer that is not ready yet hides older copies; the stall covers it.
    function automatic logic [1:0] f_fwd_d(input logic [4:0] r);
        return r == 5'd0 ? 2'b00 :
               r == r_e_a3 ? (r_e_tnew == 2'd0 ? 2'b11 : 2'b00) :
               r == r_m_a3 ? (r_m_tnew == 2'd0 ? 2'b01 : 2'b00) :
               r == r_w_a3 ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] f_fwd_e(input logic [4:0] r);
        return (r != 5'd0 && r == r_m_a3 && r_m_tnew == 2'd0) ? 2'b01 :
               (r != 5'd0 && r == r_w_a3) ? 2'b10 : 2'b00;
    endfunction

    always_comb begin
        w_stall_rs = d_rs != 5'd0 && ((r_e_a3 == d_rs && r_e_tnew > d_tuse_rs) ||
                                      (r_m_a3 == d_rs && r_m_tnew > d_tuse_rs));
        w_stall_rt = d_rt != 5'd0 && ((r_e_a3 == d_rt && r_e_tnew > d_tuse_rt) ||
                                      (r_m_a3 == d_rt && r_m_tnew > d_tuse_rt));
        stall    = w_stall_rs | w_stall_rt | w_stall_md;
        fwd_rs_d = f_fwd_d(d_rs);
        fwd_rt_d = f_fwd_d(d_rt);
        fwd_rs_e = f_fwd_e(r_e_rs);
        fwd_rt_e = f_fwd_e(r_e_rt);
        fwd_rt_m = r_m_rt != 5'd0 && r_m_rt == r_w_a3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_rs   <= '0;
            r_e_rt   <= '0;
            r_e_a3   <= '0;
            r_e_tnew <= '0;
            r_m_rt   <= '0;
            r_m_a3   <= '0;
            r_m_tnew <= '0;
            r_w_a3   <= '0;
        end else begin
            r_e_rs   <= stall ? 5'd0 : d_rs;
            r_e_rt   <= stall ? 5'd0 : d_rt;
            r_e_a3   <= stall ? 5'd0 : d_a3;
            r_e_tnew <= stall ? 2'd0 : d_tnew;
            r_m_rt   <= r_e_rt;
            r_m_a3   <= r_e_a3;
            r_m_tnew <= r_e_tnew == 2'd0 ? 2'd0 : r_e_tnew - 2'd1;
            r_w_a3   <= r_m_a3;
        end
    end

`ifdef HAZARD_MDU_EN
    logic       r_e_start, r_e_div;
    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_start <= 1'b0;
            r_e_div   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_e_start <= stall ? 1'b0 : d_md_start;
            r_e_div   <= stall ? 1'b0 : d_md_div;
            r_cnt     <= r_e_start ? (r_e_div ? 4'(DIV_LAT - 1) : 4'(MULT_LAT - 1)) :
                         r_cnt != 4'd0 ? r_cnt - 4'd1 : r_cnt;
        end
    end

    assign md_busy    = r_e_start | (r_cnt != 4'd0);
    assign w_stall_md = d_md_use & md_busy;
`else
    logic w_unused_md;
    assign w_unused_md = ^{d_md_use, d_md_start, d_md_div, MULT_LAT[0], DIV_LAT[0]};
    assign md_busy     = 1'b0;
    assign w_stall_md  = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table, MDU/reset sequences and a random run against a cycle-accurate model.
module tb_hazard_ctrl;
    localparam int ML = 5;
    localparam int DL = 10;
`ifdef HAZARD_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b1;
    logic [4:0] d_rs = '0, d_rt = '0, d_a3 = '0;
    logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
    logic       d_md_use = 1'b0, d_md_start = 1'b0, d_md_div = 1'b0;
    logic       stall, fwd_rt_m, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs),
        .d_tuse_rt(d_tuse_rt), .d_a3(d_a3), .d_tnew(d_tnew), .d_md_use(d_md_use),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .stall(stall), .fwd_rs_d(fwd_rs_d),
        .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
        .md_busy(md_busy)
    );

    // Model: each in-flight instruction remembers the absolute cycle its result is ready.
    typedef struct {logic [4:0] rs, rt, a3; int ready;} ins_t;
    ins_t s_e, s_m, s_w;
    int now = 0, busy_until = -1;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        int rs, rt, urs, urt, a3, tn;
        int st, frsd, frtd, frse, frte, frtm;
    } vec_t;
    vec_t tv[18];

    function automatic vec_t v(int rs, int rt, int urs, int urt, int a3, int tn,
                               int st, int frsd, int frtd, int frse, int frte, int frtm);
        vec_t x;
        x = '{rs, rt, urs, urt, a3, tn, st, frsd, frtd, frse, frte, frtm};
        return x;
    endfunction

    function automatic int tn(ins_t s);
        return s.ready > now ? s.ready - now : 0;
    endfunction

    function automatic bit m_haz(logic [4:0] r, logic [1:0] u);
        return r != 0 && ((s_e.a3 == r && tn(s_e) > int'(u)) || (s_m.a3 == r && tn(s_m) > int'(u)));
    endfunction

    function automatic bit m_stall();
        return m_haz(d_rs, d_tuse_rs) || m_haz(d_rt, d_tuse_rt) || (d_md_use && MDU && now <= busy_until);
    endfunction

    function automatic int m_fd(logic [4:0] r);
        if (r == 0) return 0;
        if (s_e.a3 == r) return tn(s_e) == 0 ? 3 : 0;
        if (s_m.a3 == r) return tn(s_m) == 0 ? 1 : 0;
        return s_w.a3 == r ? 2 : 0;
    endfunction

    function automatic int m_fe(logic [4:0] r);
        if (r != 0 && s_m.a3 == r && tn(s_m) == 0) return 1;
        return (r != 0 && s_w.a3 == r) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int rs, rt, urs, urt, a3, tnw, use_, st, dv);
        @(negedge clk);
        d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(urs); d_tuse_rt = 2'(urt);
        d_a3 = 5'(a3); d_tnew = 2'(tnw); d_md_use = use_[0]; d_md_start = st[0]; d_md_div = dv[0];
    endtask

    task automatic tick();
        bit st;
        @(posedge clk);
        if (reset) begin
            s_e = '{default: 0}; s_m = '{default: 0}; s_w = '{default: 0};
            busy_until = -1;
        end else begin
            st = m_stall();
            now++;
            s_w = s_m;
            s_m = s_e;
            s_e = st ? '{default: 0} : '{d_rs, d_rt, d_a3, now + int'(d_tnew)};
            if (!st && d_md_start) busy_until = now + (d_md_div ? DL : ML) - 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        #1 reset = 1'b0;
    endtask

    task automatic chk_model(input string p);
        chk({p, ".stall"}, stall, m_stall());
        chk({p, ".fwd_rs_d"}, fwd_rs_d, m_fd(d_rs));
        chk({p, ".fwd_rt_d"}, fwd_rt_d, m_fd(d_rt));
        chk({p, ".fwd_rs_e"}, fwd_rs_e, m_fe(s_e.rs));
        chk({p, ".fwd_rt_e"}, fwd_rt_e, m_fe(s_e.rt));
        chk({p, ".fwd_rt_m"}, fwd_rt_m, (s_m.rt != 0 && s_w.a3 == s_m.rt));
        chk({p, ".md_busy"}, md_busy, MDU && now <= busy_until);
    endtask

    task automatic md_seq(input bit dv, input int exp_cyc, input string nm);
        int cnt, guard;
        do_reset();
        drive(0, 0, 3, 3, 0, 0, 1, 1, dv);
        #1 chk({nm, ".issue_stall"}, stall, 0);
        tick();
        cnt = 0;
        for (guard = 0; guard < 40; guard++) begin
            drive(0, 0, 3, 3, 0, 0, 1, 0, 0);
            #1;
            if (guard == 0) chk({nm, ".busy_first"}, md_busy, MDU);
            if (!stall) break;
            cnt++;
            tick();
        end
        chk({nm, ".stall_cycles"}, cnt, exp_cyc);
        tick();
    endtask

    initial begin
        tv[0]  = v(0, 0, 3, 3, 1, 2, 0, 0, 0, 0, 0, 0);
        tv[1]  = v(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        tv[2]  = v(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        tv[3]  = v(1, 0, 0, 3, 0, 0, 0, 2, 0, 0, 0, 0);
        tv[4]  = v(0, 0, 3, 3, 2, 0, 0, 0, 0, 0, 0, 0);
        tv[5]  = v(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[6]  = v(2, 0, 1, 3, 7, 0, 0, 1, 0, 0, 0, 0);
        tv[7]  = v(0, 0, 3, 3, 0, 0, 0, 0, 0, 2, 0, 0);
        tv[8]  = v(0, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        tv[9]  = v(0, 3, 3, 2, 0, 0, 0, 0, 3, 0, 0, 0);
        tv[10] = v(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0);
        tv[11] = v(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        tv[12] = v(0, 0, 3, 3, 4, 0, 0, 0, 0, 0, 0, 0);
        tv[13] = v(0, 0, 3, 3, 4, 0, 0, 0, 0, 0, 0, 0);
        tv[14] = v(4, 4, 0, 3, 0, 0, 0, 3, 3, 0, 0, 0);
        tv[15] = v(0, 0, 3, 3, 5, 2, 0, 0, 0, 1, 1, 0);
        tv[16] = v(5, 5, 3, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        tv[17] = v(5, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tv[i].rs, tv[i].rt, tv[i].urs, tv[i].urt, tv[i].a3, tv[i].tn, 0, 0, 0);
            #1;
            chk($sformatf("vec%0d.stall", i), stall, tv[i].st);
            chk($sformatf("vec%0d.fwd_rs_d", i), fwd_rs_d, tv[i].frsd);
            chk($sformatf("vec%0d.fwd_rt_d", i), fwd_rt_d, tv[i].frtd);
            chk($sformatf("vec%0d.fwd_rs_e", i), fwd_rs_e, tv[i].frse);
            chk($sformatf("vec%0d.fwd_rt_e", i), fwd_rt_e, tv[i].frte);
            chk($sformatf("vec%0d.fwd_rt_m", i), fwd_rt_m, tv[i].frtm);
            chk($sformatf("vec%0d.md_busy", i), md_busy, 0);
            tick();
        end

        md_seq(1'b1, MDU ? DL : 0, "div");
        md_seq(1'b0, MDU ? ML : 0, "mult");

        do_reset();
        drive(0, 0, 3, 3, 1, 2, 0, 0, 0);
        tick();
        drive(0, 0, 3, 3, 0, 0, 1, 1, 1);
        tick();
        drive(1, 0, 0, 3, 0, 0, 1, 0, 0);
        #1 chk("pre_reset.stall", stall, 1);
        do_reset();
        drive(1, 0, 0, 3, 0, 0, 1, 0, 0);
        #1;
        chk("post_reset.stall", stall, 0);
        chk("post_reset.md_busy", md_busy, 0);
        chk("post_reset.fwd_rs_d", fwd_rs_d, 0);
        tick();

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            begin
                int st, use_;
                st = ($urandom_range(0, 15) == 0) ? 1 : 0;
                use_ = (st == 1 || $urandom_range(0, 7) == 0) ? 1 : 0;
                drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2),
                      use_, st, $urandom_range(0, 1));
            end
            #1 chk_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
